// File: rtl/hidden_value_streamer_pkg.sv
// Shared types and widths for the hidden-layer value streamer.
// Widths here must track the 32x8 hidden-output RAM.
package hidden_value_streamer_pkg;

    localparam int HID_DATA_W = 8;
    localparam int HID_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stream_state_e;

    typedef logic [HID_DATA_W-1:0] stream_word_t;

endpackage

// File: rtl/hidden_value_streamer_if.sv
// Valid/ready stream from the hidden-value streamer to the output-layer MAC.
interface hidden_value_streamer_if #(
    parameter int DATA_W = hidden_value_streamer_pkg::HID_DATA_W
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/hidden_value_streamer_skid_fifo2.sv
// Two-entry FIFO that absorbs the RAM read latency under output backpressure.
// Simultaneous push and pop are both honoured.
module skid_fifo2
    import hidden_value_streamer_pkg::*;
#(
    parameter int DATA_W = HID_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // The issue throttle upstream guarantees a free slot for every push.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && (count == 2'd2)));

endmodule

// File: rtl/hidden_value_streamer.sv
// Streams a window of hidden-layer activations from the hidden-output RAM
// to the output-layer MAC as a valid/ready stream.
//
// state   | meaning
// IDLE    | waiting for start; base and length latched when it arrives
// RUN     | issuing RAM reads and emitting words until the final handshake
// DONE    | one-cycle done pulse, then back to IDLE
module hidden_value_streamer
    import hidden_value_streamer_pkg::*;
#(
    parameter int DATA_W = HID_DATA_W,
    parameter int ADDR_W = HID_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_values,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [DATA_W-1:0]     ram_q,
    hidden_value_streamer_if.master out_if,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    stream_state_e     state;
    stream_state_e     state_nxt;
    logic [ADDR_W-1:0] base_lat;
    logic [ADDR_W:0]   num_lat;
    logic [ADDR_W:0]   num_sat;
    logic [ADDR_W:0]   issue_idx;
    logic [ADDR_W:0]   emit_idx;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              last_hs;
    logic [2:0]        occupancy;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;

    assign num_sat  = (num_values > DEPTH) ? DEPTH : num_values;
    assign ram_addr = base_lat + issue_idx[ADDR_W-1:0];
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    assign out_if.out_valid = (fifo_count != 2'd0);
    assign out_if.out_data  = fifo_head;
    assign out_if.out_last  = out_if.out_valid && (emit_idx == num_lat - ONE);
    assign pop              = out_if.out_valid && out_if.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        // Words that will occupy the FIFO after this edge, ignoring a new issue.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        last_hs   = pop && (emit_idx == num_lat - ONE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_values == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue = (issue_idx < num_lat) && (occupancy < 3'd2);
                if (last_hs) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_lat  <= '0;
            num_lat   <= '0;
            issue_idx <= '0;
            emit_idx  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if ((state == ST_IDLE) && start) begin
                base_lat  <= base_addr;
                num_lat   <= num_sat;
                issue_idx <= '0;
                emit_idx  <= '0;
            end else if (state == ST_RUN) begin
                if (issue) begin
                    issue_idx <= issue_idx + ONE;
                end
                if (pop) begin
                    emit_idx <= emit_idx + ONE;
                end
            end
        end
    end

    // ram_q is only meaningful the cycle after an issue.
    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .wdata (ram_q),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: doc/hidden_value_streamer.md
Name: hidden_value_streamer

Overview:
Reads a window of hidden-layer activations out of the 32x8 hidden-output RAM and presents them as a valid/ready stream to the output-layer MAC.
Drives the RAM read address and absorbs the RAM's one-cycle registered-address read latency. A 2-entry skid FIFO keeps full throughput under downstream backpressure.
Sits between the hidden-value RAM read port and the output-layer neuron datapath; the RAM write side stays owned by the hidden-layer writer.

Parameters:
DATA_W, 8, activation width; must match the RAM data width.
ADDR_W, 5, RAM address width (depth 2**ADDR_W = 32).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a stream; sampled only in IDLE.
base_addr  input  ADDR_W  first RAM address; latched on accepted start.
num_values  input  ADDR_W+1  number of words to stream, 0..32; latched on accepted start.
ram_addr  output  ADDR_W  read address to the RAM; RAM data for it is on ram_q the following cycle.
ram_q  input  DATA_W  RAM read data.
out_data  output  DATA_W  stream data (FIFO head).
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts when high together with out_valid.
out_last  output  1  high with the final word of the stream.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse after the final handshake, or after a zero-length request.

Behaviour:
- Reset (async) values: state=IDLE, issue counter=0, emit counter=0, in-flight flag=0, FIFO empty. Outputs: out_valid=0, out_last=0, busy=0, done=0, ram_addr=0.
- States:
  - IDLE: on start, latch base_addr and num_values. Go to DONE if num_values==0, else RUN. Otherwise stay in IDLE.
  - RUN: issue reads and emit words. Go to DONE on the handshake of the final word.
  - DONE: assert done for one cycle, then return to IDLE.
- start while busy is ignored. num_values > 32 is illegal; the implementation saturates it to 32.
- Addressing:
  - ram_addr = (base_latched + issue_idx) mod 2**ADDR_W, so the window wraps past address 31 to 0.
  - ram_addr is combinational from registered state.
- Read issue: in RUN, a read issues this cycle if issue_idx < num_values and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready. An issue increments issue_idx and sets inflight for the next cycle.
- Capture: on the cycle after an issue, ram_q is written into the FIFO tail at the clock edge. inflight clears unless a new issue occurs in the same cycle. ram_q is ignored whenever inflight=0, because the RAM register tracks any address.
- FIFO push and pop in the same cycle are both honoured. The FIFO never overflows by construction; an assertion must check this.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last = out_valid & (emit_idx == num_values-1); emit_idx increments on each handshake.
  - out_data is held stable while out_valid & !out_ready.
- Latency and throughput:
  - Start accepted at edge E0; ram_addr=base during the next cycle; out_valid first rises after edge E2.
  - With out_ready held high, the stream runs at one word per cycle.
  - done pulses in the cycle after the last handshake.
- Concurrent RAM writes during a stream are the system's responsibility. The streamer returns whatever the RAM holds at read time.
- Reset mid-stream: everything clears immediately; no done pulse is generated.

Decomposition:
- Shared package (nn_pkg): HID_DATA_W=8, HID_ADDR_W=5, the streamer state enum {IDLE, RUN, DONE}, and the stream word typedef.
- One natural sub-module: skid_fifo2 (2-entry FIFO, DATA_W-wide, with push/pop/count). The FSM and counters stay in the top module.

Test Plan:
1. RAM preloaded with ram[i]=i+0x10; start with base=0, num=4, out_ready=1. Required: out_valid for 4 consecutive cycles starting 2 cycles after start; data 10,11,12,13; out_last on 13; done 1 cycle later; busy low afterwards.
2. base=30, num=4. Required: addresses 30,31,0,1 in order; data 2E,2F,10,11.
3. num=6 with out_ready toggling 1,0,0,1,... Required: no lost or duplicated words, data held stable during stalls, exactly 6 handshakes, out_last only on the 6th.
4. num=0. Required: done pulses the cycle after IDLE→DONE; out_valid never asserts.
5. Second start pulsed mid-stream. Required: it is ignored and the first stream completes unchanged. A start on the cycle after done is accepted.
6. Assert rst during cycle 3 of a num=8 stream with out_ready=0. Required: out_valid, busy and done drop asynchronously. A following stream with base=5, num=2 yields ram[5], ram[6].
